// File: rtl/spi_slave_port.sv
// SPI responder: synchronises the master's pins into clk_clk, shifts in one
// word per DATA_WIDTH sample edges and shifts out a word taken from a
// one-deep transmit holding register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | not selected; MISO released and driven low
// ST_SHIFT | selected; sampling MOSI and shifting MISO on SCLK edges
module spi_slave_port #(
   parameter int                    DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic cs_s1_q, cs_s2_q, cs_s3_q;
   logic mosi_s1_q, mosi_s2_q;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic                  miso_q, miso_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  underrun_q, underrun_d;
   // first_q: next shift edge only presents the MSB (cpha=1 start of frame)
   logic                  first_q, first_d;
   // reload_q: word complete, next shift edge loads a fresh TX word
   logic                  reload_q, reload_d;

   logic                  sclk_rise, sclk_fall, lead_edge, trail_edge;
   logic                  sample_edge, shift_edge, cs_fall, cs_rise;
   logic                  load_word;
   logic [DATA_WIDTH-1:0] rx_next;

   assign sclk_rise   = sclk_s2_q & ~sclk_s3_q;
   assign sclk_fall   = ~sclk_s2_q & sclk_s3_q;
   assign lead_edge   = cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol ? sclk_rise : sclk_fall;
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge : trail_edge;
   assign cs_fall     = ~cs_s2_q & cs_s3_q;
   assign cs_rise     = cs_s2_q & ~cs_s3_q;
   assign rx_next     = {rx_sr_q[DATA_WIDTH-2:0], mosi_s2_q};

   assign spi_miso    = miso_q;
   assign tx_ready    = ~hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = underrun_q;

   // Two-stage synchronisers plus history stage for edge detection.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         sclk_s1_q <= cpol;
         sclk_s2_q <= cpol;
         sclk_s3_q <= cpol;
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         cs_s3_q   <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         sclk_s1_q <= spi_sclk;
         sclk_s2_q <= sclk_s1_q;
         sclk_s3_q <= sclk_s2_q;
         cs_s1_q   <= spi_cs_n;
         cs_s2_q   <= cs_s1_q;
         cs_s3_q   <= cs_s2_q;
         mosi_s1_q <= spi_mosi;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   // State register together with the shift/holding datapath registers.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         rx_data_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         miso_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         first_q     <= 1'b0;
         reload_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         rx_data_q   <= rx_data_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         miso_q      <= miso_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         first_q     <= first_d;
         reload_q    <= reload_d;
      end
   end

   // Next state: chip select edges alone move the FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
         ST_SHIFT: if (cs_rise) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      busy        = (state_q == ST_SHIFT);
      spi_miso_oe = (state_q == ST_SHIFT);
   end

   // Datapath: sampling, shifting, word completion, reloads and holding register.
   always_comb begin
      cnt_d       = cnt_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      rx_data_d   = rx_data_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      miso_d      = miso_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      first_d     = first_q;
      reload_d    = reload_q;
      load_word   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               cnt_d     = '0;
               first_d   = cpha;
               reload_d  = 1'b0;
               load_word = 1'b1;
            end
         end
         ST_SHIFT: begin
            // CS wins over a coincident SCLK edge; the partial word is dropped.
            if (cs_rise) begin
               cnt_d    = '0;
               miso_d   = 1'b0;
               first_d  = 1'b0;
               reload_d = 1'b0;
            end else begin
               if (sample_edge) begin
                  rx_sr_d = rx_next;
                  if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                     rx_data_d  = rx_next;
                     rx_valid_d = 1'b1;
                     cnt_d      = '0;
                     reload_d   = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               if (shift_edge) begin
                  if (reload_q) begin
                     reload_d  = 1'b0;
                     load_word = 1'b1;
                  end else if (first_q) begin
                     first_d = 1'b0;
                  end else begin
                     tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                     miso_d  = tx_sr_q[DATA_WIDTH-2];
                  end
               end
            end
         end
         default: ;
      endcase

      // A load only sees words accepted in earlier cycles.
      if (load_word) begin
         if (hold_full_q) begin
            tx_sr_d     = hold_q;
            hold_full_d = 1'b0;
         end else begin
            tx_sr_d    = IDLE_WORD;
            underrun_d = 1'b1;
         end
         miso_d = tx_sr_d[DATA_WIDTH-1];
      end

      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a bit-banged SPI master drives frames, a word-level
// model predicts which TX words go out and which RX words arrive, and a
// monitor compares every rx_valid against the expected-word queue.
module tb_spi_slave_port;

   localparam int             DW = 16;
   localparam logic [DW-1:0]  IW = 16'hFFFF;
   localparam int             H  = 6;

   logic          clk_clk = 1'b0;
   logic          reset_reset_n;
   logic          cpol, cpha;
   logic          spi_sclk, spi_cs_n, spi_mosi;
   logic          spi_miso, spi_miso_oe;
   logic [DW-1:0] tx_data;
   logic          tx_valid, tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid, tx_underrun, busy;

   int checks = 0;
   int errors = 0;
   int under_seen = 0;
   int under_exp = 0;

   logic [DW-1:0] rx_exp[$];
   logic [DW-1:0] hold_model[$];
   logic [DW-1:0] fw_mosi[4];
   bit            fw_offer_en[4];
   logic [DW-1:0] fw_offer[4];
   logic [DW-1:0] exp_tx[5];

   spi_slave_port #(.DATA_WIDTH(DW), .IDLE_WORD(IW)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .cpol(cpol), .cpha(cpha),
      .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_underrun(tx_underrun), .busy(busy)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every rx_valid pulse must match the oldest expected word.
   always @(negedge clk_clk) begin
      if (rx_valid) begin
         if (rx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected actual=%0h expected=none", rx_data);
         end else begin
            check("rx_data", rx_data, rx_exp.pop_front());
         end
      end
      if (tx_underrun) under_seen++;
   end

   // Word start: take the pending holding word, else the idle word with an underrun.
   function automatic logic [DW-1:0] start_word();
      if (hold_model.size() > 0) return hold_model.pop_front();
      under_exp++;
      return IW;
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   task automatic offer(input logic [DW-1:0] d);
      @(posedge clk_clk);
      #1;
      check("tx_ready_empty", tx_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk_clk);
      #1;
      tx_valid = 1'b0;
      check("tx_ready_taken", tx_ready, 0);
      hold_model.push_back(d);
   endtask

   task automatic half(input bit try_offer, input logic [DW-1:0] d);
      if (try_offer && hold_model.size() == 0) begin
         offer(d);
         wait_clks(H - 2);
      end else begin
         wait_clks(H);
      end
   endtask

   task automatic check_reset();
      check("rst_miso", spi_miso, 0);
      check("rst_oe", spi_miso_oe, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_underrun", tx_underrun, 0);
      check("rst_busy", busy, 0);
   endtask

   task automatic clear_fw();
      for (int i = 0; i < 4; i++) begin
         fw_mosi[i]     = '0;
         fw_offer_en[i] = 1'b0;
         fw_offer[i]    = '0;
      end
   endtask

   // One CS frame: nfull complete words followed by k bits of a partial word.
   task automatic frame(input bit pol, input bit pha, input int nfull, input int k);
      logic [DW-1:0] cap;
      int bits;
      if (pol != cpol) begin
         cpol     = pol;
         spi_sclk = pol;
         wait_clks(4);
      end
      cpha      = pha;
      spi_mosi  = fw_mosi[0][DW-1];
      spi_cs_n  = 1'b0;
      exp_tx[0] = start_word();
      wait_clks(2);
      check("oe_before_sync", spi_miso_oe, 0);
      wait_clks(1);
      check("oe_after_sync", spi_miso_oe, 1);
      check("busy_after_sync", busy, 1);
      wait_clks(H - 3);
      for (int i = 0; i <= nfull; i++) begin
         bits = (i < nfull) ? DW : k;
         if (bits == 0) break;
         if (i > 0 && pha) exp_tx[i] = start_word();
         if (i < nfull) rx_exp.push_back(fw_mosi[i]);
         cap = '0;
         for (int b = 0; b < bits; b++) begin
            if (!pha) begin
               spi_mosi = fw_mosi[i][DW-1-b];
               half(b == 8 && fw_offer_en[i], fw_offer[i]);
               cap[DW-1-b] = spi_miso;
               spi_sclk = ~pol;
               half(1'b0, '0);
               spi_sclk = pol;
            end else begin
               spi_sclk = ~pol;
               spi_mosi = fw_mosi[i][DW-1-b];
               half(b == 8 && fw_offer_en[i], fw_offer[i]);
               cap[DW-1-b] = spi_miso;
               spi_sclk = pol;
               half(1'b0, '0);
            end
         end
         if (i < nfull) begin
            check("miso_word", cap, exp_tx[i]);
            if (!pha) exp_tx[i+1] = start_word();
         end
      end
      wait_clks(H);
      spi_cs_n = 1'b1;
      wait_clks(3);
      check("oe_release", spi_miso_oe, 0);
      check("busy_release", busy, 0);
      check("miso_release", spi_miso, 0);
      wait_clks(4);
      check("rx_pending", rx_exp.size(), 0);
      check("underrun_count", under_seen, under_exp);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset_reset_n = 1'b0;
      cpol = 1'b0; cpha = 1'b0;
      spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
      tx_data = '0; tx_valid = 1'b0;
      clear_fw();
      wait_clks(3);
      check_reset();
      reset_reset_n = 1'b1;
      wait_clks(4);

      // Mode 0, preloaded A55A; a refill keeps the end-of-word reload fed.
      offer(16'hA55A);
      fw_mosi[0] = 16'h1234; fw_offer_en[0] = 1'b1; fw_offer[0] = 16'h0BAD;
      frame(1'b0, 1'b0, 1, 0);

      // Modes 1..3, BEEF in / 0F0F out.
      for (int m = 1; m < 4; m++) begin
         clear_fw();
         fw_mosi[0] = 16'hBEEF;
         if (hold_model.size() == 0) offer(16'h0F0F);
         frame(m[1], m[0], 1, 0);
      end

      // Two words in one frame, refilled during the first word.
      clear_fw();
      fw_mosi[0] = 16'h0001; fw_mosi[1] = 16'h0002;
      fw_offer_en[0] = 1'b1; fw_offer[0] = 16'hF00D;
      if (hold_model.size() == 0) offer(16'hC0DE);
      frame(1'b1, 1'b1, 2, 0);

      // No TX data: idle word with one underrun.
      clear_fw();
      fw_mosi[0] = 16'h3C3C;
      frame(1'b0, 1'b1, 1, 0);

      // Aborted after 7 bits, then a full 5555 frame.
      clear_fw();
      fw_mosi[0] = 16'hFFFF;
      frame(1'b0, 1'b0, 0, 7);
      clear_fw();
      fw_mosi[0] = 16'h5555;
      if (hold_model.size() == 0) offer(16'h1357);
      frame(1'b0, 1'b0, 1, 0);

      // Reset in the middle of a word.
      if (hold_model.size() == 0) offer(16'h1111);
      cpha = 1'b0;
      spi_mosi = 1'b1;
      spi_cs_n = 1'b0;
      void'(start_word());
      wait_clks(H);
      for (int b = 0; b < 5; b++) begin
         spi_sclk = 1'b1; wait_clks(H);
         spi_sclk = 1'b0; wait_clks(H);
      end
      reset_reset_n = 1'b0;
      spi_cs_n = 1'b1;
      wait_clks(1);
      check_reset();
      wait_clks(2);
      reset_reset_n = 1'b1;
      hold_model.delete();
      wait_clks(4);
      clear_fw();
      fw_mosi[0] = 16'h8001;
      offer(16'h2468);
      frame(1'b0, 1'b0, 1, 0);

      // Randomised frames across all modes.
      repeat (20) begin
         int nf, kb;
         bit p, q;
         p  = 1'($urandom_range(0, 1));
         q  = 1'($urandom_range(0, 1));
         nf = $urandom_range(1, 3);
         kb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
         for (int i = 0; i < 4; i++) begin
            fw_mosi[i]     = DW'($urandom);
            fw_offer_en[i] = 1'($urandom_range(0, 1));
            fw_offer[i]    = DW'($urandom);
         end
         if ($urandom_range(0, 1) == 1 && hold_model.size() == 0) offer(DW'($urandom));
         frame(p, q, nf, kb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

Word-oriented SPI slave (responder) for the FPGA fabric: the far end of the SPI master whose pins are exported as `port_baudrate` (SCLK), `port_spi_cs*`, `port_spi_tx` (MOSI) and `port_spi_rx` (MISO). The block synchronises the external SPI pins into the system clock domain, shifts in one word per `DATA_WIDTH` SCLK sample edges, and shifts out a word loaded from a one-deep transmit holding register. It sits beside the HPS bridge logic, so a second board (or a loopback) can talk to the master under test.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per SPI word, 4..32.
- `IDLE_WORD`, 0: word shifted out when no transmit data is pending.

Ports:
- `clk_clk`  in  1  system clock; all logic on rising edge.
- `reset_reset_n`  in  1  synchronous, active-low reset.
- `cpol`  in  1  SCLK idle level; static while `busy`=1.
- `cpha`  in  1  0: sample leading edge / shift trailing edge; 1: shift leading / sample trailing.
- `spi_sclk`  in  1  SCLK from master (async).
- `spi_cs_n`  in  1  chip select, active low (async).
- `spi_mosi`  in  1  master-out data (async).
- `spi_miso`  out  1  slave-out data, MSB first.
- `spi_miso_oe`  out  1  MISO output enable; high only while selected.
- `tx_data`  in  DATA_WIDTH  next word to send.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  holding register empty.
- `rx_data`  out  DATA_WIDTH  last complete received word.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` updated.
- `tx_underrun`  out  1  one-cycle pulse, word started with holding register empty.
- `busy`  out  1  chip select seen asserted (synchronised).

## Operation
- `spi_sclk`, `spi_cs_n`, `spi_mosi` each pass a 2-FF synchroniser plus one history FF; edges detected by comparing stage 2 and stage 3.
- Leading edge = rising when `cpol`=0, falling when `cpol`=1; trailing edge the opposite.
- TX holding register: accepted when `tx_valid && tx_ready`; `tx_ready` drops the next cycle, rises the cycle after the holding register is consumed into the shift register.
- States: IDLE, SHIFT.
  - IDLE -> SHIFT on synchronised CS falling edge: bit counter = 0; TX shift register loaded from holding register (consumes it) or `IDLE_WORD` with `tx_underrun` pulse; `spi_miso_oe`=1; `spi_miso` = TX MSB.
  - SHIFT: on each sample edge, synchronised MOSI shifts into RX shift register LSB, counter +1. On each shift edge, TX shift register shifts left, `spi_miso` = new MSB. With `cpha`=1 the first leading edge drives MSB (no shift before the first bit).
  - Counter reaching `DATA_WIDTH`: `rx_data` <= RX shift register including the final bit, `rx_valid` pulse, counter = 0, TX shift register reloaded (same rules, same underrun pulse) at the next shift-edge point, so back-to-back words need no CS toggle.
  - SHIFT -> IDLE on synchronised CS rising edge: partial word discarded, no `rx_valid`, counter cleared, `spi_miso_oe`=0, `spi_miso`=0; a holding-register word not yet consumed stays pending.
- CS edge and SCLK edge in the same cycle: CS handled first; SCLK edge ignored.
- `tx_valid` with `tx_ready`=1 in the same cycle as a reload: new word accepted into holding register, not the reload (reload sees it as empty -> underrun).

## Timing
- Reset (`reset_reset_n`=0 at a clock edge): state IDLE, `spi_miso`=0, `spi_miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `busy`=0, synchronisers cleared to CS high, SCLK=`cpol`. Reset mid-word abandons the word with no pulses.
- CS falling at pin -> `spi_miso_oe`/`busy` high: 3 clk cycles.
- Final sample SCLK edge at pin -> `rx_valid`: 3 clk cycles.
- Requirement: SCLK high and low times each >= 4 `clk_clk` periods; CS setup to first SCLK edge >= 4 periods.
- `rx_valid` has no backpressure; a new word overwrites `rx_data`.

## Test plan
- Mode 0, DATA_WIDTH 16, preload `tx_data`=0xA55A, master sends 0x1234 -> MISO bits read 0xA55A, `rx_data`=0x1234, one `rx_valid`, no `tx_underrun`.
- Modes 1, 2, 3 each: master sends 0xBEEF, slave sends 0x0F0F -> exchange exact in both directions.
- Two words in one CS frame, holding register refilled after first reload: 0x0001, 0x0002 in, 0xC0DE, 0xF00D out -> two `rx_valid` pulses, correct data, `tx_ready` toggles once per word.
- No TX data, `IDLE_WORD`=0xFFFF -> `tx_underrun` pulses once at CS assertion, MISO all ones, `rx_data` still correct.
- CS deasserted after 7 of 16 bits -> no `rx_valid`, `spi_miso_oe`=0 within 3 cycles; next full frame 0x5555 received correctly.
- Reset asserted mid-word -> all outputs at reset values next cycle; following frame 0x8001 received correctly.
